// File: rtl/axi4_lite_ram_slave.sv
// +--------------------------------------------------------------------------+
// | Module   : axi4_lite_ram_slave                                           |
// | Desc     : AXI4-Lite slave backed by a word-addressed RAM with byte      |
// |            strobes; independent write and read channel FSMs.            |
// |            Optional macro AXI_SLV_ERR_EN: SLVERR for out-of-range access.|
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4_lite_ram_slave #(
   parameter int          MEM_DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready
);

   localparam int          IDX_W      = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
   localparam logic [32:0] c_mem_size = 33'(MEM_DEPTH_WORDS) * 33'd4;
`ifdef AXI_SLV_ERR_EN
   localparam logic [1:0]  c_oor_resp = 2'b10;
`else
   localparam logic [1:0]  c_oor_resp = 2'b00;
`endif

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

   logic [31:0] mem [MEM_DEPTH_WORDS];

   // ---------------- write channel ----------------
   wr_state_t   r_wst, w_wst_nxt;
   logic        r_aw_held, r_w_held, w_aw_held_nxt, w_w_held_nxt;
   logic [31:0] r_awaddr, r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_awready, r_wready, r_bvalid, w_bvalid_nxt;
   logic [1:0]  r_bresp, w_bresp_nxt;
   logic        w_aw_hs, w_w_hs, w_commit;
   logic [31:0] w_wr_addr, w_wr_data, w_wr_off;
   logic [3:0]  w_wr_strb;
   logic        w_wr_in_range;
   logic [IDX_W-1:0] w_wr_idx;

   assign w_aw_hs       = awvalid && r_awready;
   assign w_w_hs        = wvalid && r_wready;
   assign w_wr_addr     = r_aw_held ? r_awaddr : awaddr;
   assign w_wr_data     = r_w_held  ? r_wdata  : wdata;
   assign w_wr_strb     = r_w_held  ? r_wstrb  : wstrb;
   assign w_wr_off      = w_wr_addr - BASE_ADDR;
   assign w_wr_in_range = {1'b0, w_wr_off} < c_mem_size;
   assign w_wr_idx      = w_wr_off[IDX_W+1:2];

   always_comb begin
      w_wst_nxt     = r_wst;
      w_aw_held_nxt = r_aw_held;
      w_w_held_nxt  = r_w_held;
      w_bvalid_nxt  = r_bvalid;
      w_bresp_nxt   = r_bresp;
      w_commit      = 1'b0;
      case (r_wst)
         W_IDLE: begin
            w_aw_held_nxt = r_aw_held || w_aw_hs;
            w_w_held_nxt  = r_w_held  || w_w_hs;
            if (w_aw_held_nxt && w_w_held_nxt) begin
               w_commit      = 1'b1;
               w_aw_held_nxt = 1'b0;
               w_w_held_nxt  = 1'b0;
               w_bvalid_nxt  = 1'b1;
               w_bresp_nxt   = w_wr_in_range ? 2'b00 : c_oor_resp;
               w_wst_nxt     = W_RESP;
            end
         end
         W_RESP: begin
            if (r_bvalid && bready) begin
               w_bvalid_nxt = 1'b0;
               w_wst_nxt    = W_IDLE;
            end
         end
         default: w_wst_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wst     <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_wst     <= w_wst_nxt;
         r_aw_held <= w_aw_held_nxt;
         r_w_held  <= w_w_held_nxt;
         if (w_aw_hs) r_awaddr <= awaddr;
         if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
         end
         // Ready reflects "not yet captured" for the cycle after this edge
         r_awready <= (w_wst_nxt == W_IDLE) && !w_aw_held_nxt;
         r_wready  <= (w_wst_nxt == W_IDLE) && !w_w_held_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_bresp   <= w_bresp_nxt;
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (w_commit && w_wr_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (w_wr_strb[i]) mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   rd_state_t   r_rst_q, w_rst_nxt;
   logic        r_arready, r_rvalid, w_rvalid_nxt, w_ar_hs;
   logic [31:0] r_rdata, w_rd_off;
   logic [1:0]  r_rresp;
   logic        w_rd_in_range;
   logic [IDX_W-1:0] w_rd_idx;

   assign w_ar_hs       = arvalid && r_arready;
   assign w_rd_off      = araddr - BASE_ADDR;
   assign w_rd_in_range = {1'b0, w_rd_off} < c_mem_size;
   assign w_rd_idx      = w_rd_off[IDX_W+1:2];

   always_comb begin
      w_rst_nxt    = r_rst_q;
      w_rvalid_nxt = r_rvalid;
      case (r_rst_q)
         R_IDLE: begin
            if (w_ar_hs) begin
               w_rvalid_nxt = 1'b1;
               w_rst_nxt    = R_DATA;
            end
         end
         R_DATA: begin
            if (r_rvalid && rready) begin
               w_rvalid_nxt = 1'b0;
               w_rst_nxt    = R_IDLE;
            end
         end
         default: w_rst_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rst_q   <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
      end else begin
         r_rst_q   <= w_rst_nxt;
         r_arready <= (w_rst_nxt == R_IDLE);
         r_rvalid  <= w_rvalid_nxt;
         // Nonblocking sample gives read-before-write against a same-edge commit
         if (w_ar_hs) begin
            r_rdata <= w_rd_in_range ? mem[w_rd_idx] : 32'h0000_0000;
            r_rresp <= w_rd_in_range ? 2'b00 : c_oor_resp;
         end
      end
   end

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;

endmodule

`default_nettype wire

// File: doc/axi4_lite_ram_slave.md
AXI4_LITE_RAM_SLAVE -- requirements
Module: axi4_lite_ram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH_WORDS, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have ports: clk input 1, the single clock; all logic on rising edge.
REQ-004 SHALL have ports: rst input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: awaddr input 32, write address; awvalid input 1; awready output 1.
REQ-006 SHALL have ports: wdata input 32, write data; wstrb input 4, byte enables; wvalid input 1; wready output 1.
REQ-007 SHALL have ports: bresp output 2, write response; bvalid output 1; bready input 1.
REQ-008 SHALL have ports: araddr input 32, read address; arvalid input 1; arready output 1.
REQ-009 SHALL have ports: rdata output 32, read data; rresp output 2, read response; rvalid output 1; rready input 1.

Function
REQ-010 SHALL decode word index as (addr - BASE_ADDR) >> 2; addr[1:0] ignored; in range iff offset < MEM_DEPTH_WORDS*4.
REQ-011 SHALL run write FSM states W_IDLE, W_RESP; read FSM states R_IDLE, R_DATA, fully independent.
REQ-012 SHALL, in W_IDLE, hold awready high until AW captured and wready high until W captured; AW and W accepted in any order or the same cycle.
REQ-013 SHALL, on the cycle both AW and W are held, write each byte lane i where wstrb[i]=1 (in range only), drop awready/wready, set bvalid=1 next cycle, enter W_RESP.
REQ-014 SHALL hold bvalid, bresp stable in W_RESP until bvalid&&bready, then clear bvalid and return to W_IDLE with awready/wready high next cycle.
REQ-015 SHALL, in R_IDLE, hold arready high; on arvalid&&arready capture araddr, register memory word into rdata, set rvalid=1 next cycle (1-cycle latency), drop arready, enter R_DATA.
REQ-016 SHALL hold rdata, rresp, rvalid stable in R_DATA until rvalid&&rready, then clear rvalid, return to R_IDLE.
REQ-017 SHALL return old data when a read samples the same word in the same cycle a write commits (read-before-write).
REQ-018 SHALL ignore wstrb=4'b0000 writes (memory unchanged) but still complete the B handshake with OKAY.
REQ-019 SHALL never assert bvalid or rvalid without a preceding accepted request; never accept a new request while the corresponding response is pending.
REQ-020 SHALL allow bready/rready held high before valid; handshake then completes the cycle valid rises.

Reset
REQ-021 SHALL, while rst=0, force awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0, both FSMs to IDLE, capture flags cleared.
REQ-022 SHALL drop any in-flight transaction on reset mid-operation; a partially captured AW/W commits no write.
REQ-023 SHALL assert awready, wready, arready on the first rising clk edge after rst deasserts; memory contents not reset.

Configuration
REQ-024 SHALL, with AXI_SLV_ERR_EN defined, return bresp/rresp=2'b10 (SLVERR) for out-of-range addresses, rdata=0, no write.
REQ-025 SHALL, without AXI_SLV_ERR_EN, return OKAY (2'b00) for out-of-range, discard writes, rdata=32'h0000_0000.

Verification
REQ-026 SHALL cover: AW and W same cycle, addr 0x10, wdata 0xDEADBEEF, wstrb 4'b1111, bready=1 -> bvalid one cycle later, bresp 00; read 0x10 -> rvalid one cycle after AR handshake, rdata 0xDEADBEEF.
REQ-027 SHALL cover: W two cycles before AW, addr 0x10, wdata 0x000000AA, wstrb 4'b0001 -> read 0x10 returns 0xDEADBEAA.
REQ-028 SHALL cover: rready held low 5 cycles after rvalid -> rdata/rvalid stable, arready low throughout, arready high after handshake.
REQ-029 SHALL cover: read addr BASE_ADDR+4096 with MEM_DEPTH_WORDS=1024 -> rresp 2'b10, rdata 0 with AXI_SLV_ERR_EN; rresp 2'b00, rdata 0 without.
REQ-030 SHALL cover: rst pulled low after AW accepted, before W -> all valids 0; subsequent read of that address returns prior contents.
